// File: rtl/uarch_pkg.sv
// Shared micro-architecture definitions for the rename slice.
// Holds the map-table entry type and default sizes.
package uarch_pkg;

  localparam int TAG_W     = 6;
  localparam int NUM_AREGS = 32;
  localparam int AREG_W    = $clog2(NUM_AREGS);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } rat_entry_t;

endpackage

// File: rtl/rename_nw_if.sv
// Decode, ROB, commit and dispatch signals of the rename stage.
// slave = rename stage, master = its surroundings.
interface rename_nw_if #(
  parameter int WIDTH     = 4,
  parameter int AREG_W    = 5,
  parameter int TAG_W     = 6,
  parameter int NCOMMIT   = 2,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = $clog2(WIDTH + 1)
);

  logic                         flush;
  logic [WIDTH-1:0]             dec_valid;
  logic [WIDTH*AREG_W-1:0]      dec_rs1;
  logic [WIDTH*AREG_W-1:0]      dec_rs2;
  logic [WIDTH*AREG_W-1:0]      dec_rd;
  logic [WIDTH-1:0]             dec_has_rd;
  logic [WIDTH*PAYLOAD_W-1:0]   dec_payload;
  logic [CNT_W-1:0]             dec_accept_cnt;
  logic [CNT_W-1:0]             rob_req_cnt;
  logic [CNT_W-1:0]             rob_gnt_cnt;
  logic [TAG_W-1:0]             rob_tag_base;
  logic [NCOMMIT-1:0]           commit_valid;
  logic [NCOMMIT*AREG_W-1:0]    commit_rd;
  logic [NCOMMIT*TAG_W-1:0]     commit_tag;
  logic                         disp_rdy;
  logic [WIDTH-1:0]             ren_valid;
  logic [WIDTH*TAG_W-1:0]       ren_dest_tag;
  logic [WIDTH-1:0]             ren_rs1_renamed;
  logic [WIDTH-1:0]             ren_rs2_renamed;
  logic [WIDTH*TAG_W-1:0]       ren_rs1_tag;
  logic [WIDTH*TAG_W-1:0]       ren_rs2_tag;
  logic [WIDTH*PAYLOAD_W-1:0]   ren_payload;

  modport slave (
    input  flush, dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  dec_has_rd, dec_payload, rob_gnt_cnt, rob_tag_base,
    input  commit_valid, commit_rd, commit_tag, disp_rdy,
    output dec_accept_cnt, rob_req_cnt, ren_valid, ren_dest_tag,
    output ren_rs1_renamed, ren_rs2_renamed,
    output ren_rs1_tag, ren_rs2_tag, ren_payload
  );

  modport master (
    output flush, dec_valid, dec_rs1, dec_rs2, dec_rd,
    output dec_has_rd, dec_payload, rob_gnt_cnt, rob_tag_base,
    output commit_valid, commit_rd, commit_tag, disp_rdy,
    input  dec_accept_cnt, rob_req_cnt, ren_valid, ren_dest_tag,
    input  ren_rs1_renamed, ren_rs2_renamed,
    input  ren_rs1_tag, ren_rs2_tag, ren_payload
  );

endinterface

// File: rtl/rename_rat.sv
// Register alias table: bypassed reads, youngest-wins writes,
// tag-matched commit clears and flush clear.
module rename_rat
  import uarch_pkg::*;
#(
  parameter int NUM_AREGS = uarch_pkg::NUM_AREGS,
  parameter int AREG_W    = $clog2(NUM_AREGS),
  parameter int TAG_W     = uarch_pkg::TAG_W,
  parameter int WIDTH     = 4,
  parameter int NCOMMIT   = 2,
  parameter int NRD       = 2 * WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NRD*AREG_W-1:0]     rd_addr,
  output logic [NRD-1:0]            rd_hit,
  output logic [NRD*TAG_W-1:0]      rd_tag,
  input  logic [WIDTH-1:0]          wr_en,
  input  logic [WIDTH*AREG_W-1:0]   wr_addr,
  input  logic [WIDTH*TAG_W-1:0]    wr_tag,
  input  logic [NCOMMIT-1:0]        cm_valid,
  input  logic [NCOMMIT*AREG_W-1:0] cm_rd,
  input  logic [NCOMMIT*TAG_W-1:0]  cm_tag
);

  logic [NUM_AREGS-1:0] valid;
  logic [TAG_W-1:0]     tag [NUM_AREGS];

  for (genvar q = 0; q < NRD; q++) begin : g_rd
    logic [AREG_W-1:0] a;
    logic              clr;
    assign a = rd_addr[q*AREG_W +: AREG_W];
    // a commit retiring this mapping this cycle is seen by the read
    always_comb begin
      clr = 1'b0;
      for (int p = 0; p < NCOMMIT; p++)
        if (cm_valid[p] &&
            cm_rd[p*AREG_W +: AREG_W] == a &&
            cm_tag[p*TAG_W +: TAG_W] == tag[a])
          clr = 1'b1;
    end
    assign rd_hit[q] = valid[a] & ~clr;
    assign rd_tag[q*TAG_W +: TAG_W] = rd_hit[q] ? tag[a] : '0;
  end

  // later statements win: clears first, then writes oldest to youngest
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else begin
      for (int p = 0; p < NCOMMIT; p++)
        if (cm_valid[p] &&
            valid[cm_rd[p*AREG_W +: AREG_W]] &&
            tag[cm_rd[p*AREG_W +: AREG_W]] == cm_tag[p*TAG_W +: TAG_W])
          valid[cm_rd[p*AREG_W +: AREG_W]] <= 1'b0;
      for (int i = 0; i < WIDTH; i++)
        if (wr_en[i] && wr_addr[i*AREG_W +: AREG_W] != '0)
          valid[wr_addr[i*AREG_W +: AREG_W]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < WIDTH; i++)
        if (wr_en[i] && wr_addr[i*AREG_W +: AREG_W] != '0)
          tag[wr_addr[i*AREG_W +: AREG_W]] <= wr_tag[i*TAG_W +: TAG_W];
    end
  end

endmodule

// File: rtl/rename_nw.sv
// N-wide rename stage: grant prefix, in-group dependency mux,
// tag allocation and registered output group toward dispatch.
module rename_nw
  import uarch_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_AREGS = uarch_pkg::NUM_AREGS,
  parameter int TAG_W     = uarch_pkg::TAG_W,
  parameter int NCOMMIT   = 2,
  parameter int PAYLOAD_W = 64,
  parameter int AREG_W    = $clog2(NUM_AREGS),
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  rename_nw_if.slave  bus
);

  logic                       advance;
  logic                       open;
  logic [CNT_W-1:0]           pop;
  logic [WIDTH-1:0]           acc;
  logic [WIDTH-1:0]           wr_en;
  logic [WIDTH*TAG_W-1:0]     dtag;
  logic [2*WIDTH*AREG_W-1:0]  rd_addr;
  logic [2*WIDTH-1:0]         rd_hit;
  logic [2*WIDTH*TAG_W-1:0]   rd_tag;
  logic [2*WIDTH-1:0]         src_hit;
  logic [2*WIDTH*TAG_W-1:0]   src_tag;
  logic [WIDTH*TAG_W-1:0]     nxt_dest;
  logic [WIDTH*PAYLOAD_W-1:0] nxt_payload;

  assign advance = ~|bus.ren_valid | bus.disp_rdy;
  assign open    = advance & ~rst & ~bus.flush;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++)
      pop = pop + CNT_W'(bus.dec_valid[i]);
  end

  assign bus.rob_req_cnt    = open ? pop : '0;
  assign bus.dec_accept_cnt = open ? bus.rob_gnt_cnt : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [AREG_W-1:0] rd;
    assign rd = bus.dec_rd[i*AREG_W +: AREG_W];
    assign acc[i] = open & bus.dec_valid[i] &
                    (CNT_W'(i) < bus.rob_gnt_cnt);
    assign wr_en[i] = acc[i] & bus.dec_has_rd[i] & (rd != '0);
    assign dtag[i*TAG_W +: TAG_W] = bus.rob_tag_base + TAG_W'(i);
    assign rd_addr[(2*i)*AREG_W +: AREG_W] =
      bus.dec_rs1[i*AREG_W +: AREG_W];
    assign rd_addr[(2*i+1)*AREG_W +: AREG_W] =
      bus.dec_rs2[i*AREG_W +: AREG_W];
    assign nxt_dest[i*TAG_W +: TAG_W] =
      acc[i] ? dtag[i*TAG_W +: TAG_W] : '0;
    assign nxt_payload[i*PAYLOAD_W +: PAYLOAD_W] =
      acc[i] ? bus.dec_payload[i*PAYLOAD_W +: PAYLOAD_W] : '0;
  end

  // scan older lanes in age order so the youngest writer overrides
  for (genvar q = 0; q < 2 * WIDTH; q++) begin : g_src
    localparam int L = q / 2;
    logic [AREG_W-1:0] r;
    logic              hit;
    logic [TAG_W-1:0]  tg;
    assign r = rd_addr[q*AREG_W +: AREG_W];
    always_comb begin
      hit = rd_hit[q];
      tg  = rd_tag[q*TAG_W +: TAG_W];
      for (int j = 0; j < L; j++)
        if (wr_en[j] && bus.dec_rd[j*AREG_W +: AREG_W] == r) begin
          hit = 1'b1;
          tg  = dtag[j*TAG_W +: TAG_W];
        end
    end
    assign src_hit[q] = acc[L] & hit;
    assign src_tag[q*TAG_W +: TAG_W] = src_hit[q] ? tg : '0;
  end

  rename_rat #(
    .NUM_AREGS (NUM_AREGS),
    .AREG_W    (AREG_W),
    .TAG_W     (TAG_W),
    .WIDTH     (WIDTH),
    .NCOMMIT   (NCOMMIT)
  ) u_rat (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .rd_addr  (rd_addr),
    .rd_hit   (rd_hit),
    .rd_tag   (rd_tag),
    .wr_en    (wr_en),
    .wr_addr  (bus.dec_rd),
    .wr_tag   (dtag),
    .cm_valid (bus.commit_valid),
    .cm_rd    (bus.commit_rd),
    .cm_tag   (bus.commit_tag)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      bus.ren_valid       <= '0;
      bus.ren_dest_tag    <= '0;
      bus.ren_rs1_renamed <= '0;
      bus.ren_rs2_renamed <= '0;
      bus.ren_rs1_tag     <= '0;
      bus.ren_rs2_tag     <= '0;
      bus.ren_payload     <= '0;
    end else if (advance) begin
      bus.ren_valid    <= acc;
      bus.ren_dest_tag <= nxt_dest;
      bus.ren_payload  <= nxt_payload;
      for (int i = 0; i < WIDTH; i++) begin
        bus.ren_rs1_renamed[i] <= src_hit[2*i];
        bus.ren_rs2_renamed[i] <= src_hit[2*i+1];
        bus.ren_rs1_tag[i*TAG_W +: TAG_W] <=
          src_tag[(2*i)*TAG_W +: TAG_W];
        bus.ren_rs2_tag[i*TAG_W +: TAG_W] <=
          src_tag[(2*i+1)*TAG_W +: TAG_W];
      end
    end
  end

endmodule

// File: tb/tb_rename_nw.sv
// Directed bench for rename_nw: chains, partial grants, wrap,
// commit races, backpressure, flush and x0 handling.
module tb_rename_nw;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rename_nw_if #(
    .WIDTH(4), .AREG_W(5), .TAG_W(6), .NCOMMIT(2), .PAYLOAD_W(64)
  ) bus ();

  rename_nw #(
    .WIDTH(4), .NUM_AREGS(32), .TAG_W(6), .NCOMMIT(2), .PAYLOAD_W(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush        = 1'b0;
    bus.dec_valid    = '0;
    bus.dec_rs1      = '0;
    bus.dec_rs2      = '0;
    bus.dec_rd       = '0;
    bus.dec_has_rd   = '0;
    bus.dec_payload  = '0;
    bus.rob_gnt_cnt  = '0;
    bus.rob_tag_base = '0;
    bus.commit_valid = '0;
    bus.commit_rd    = '0;
    bus.commit_tag   = '0;
    bus.disp_rdy     = 1'b1;
  endtask

  task automatic lane(input int i, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [4:0] d,
                      input logic h, input logic [63:0] pl);
    bus.dec_valid[i]         = 1'b1;
    bus.dec_rs1[i*5 +: 5]    = s1;
    bus.dec_rs2[i*5 +: 5]    = s2;
    bus.dec_rd[i*5 +: 5]     = d;
    bus.dec_has_rd[i]        = h;
    bus.dec_payload[i*64 +: 64] = pl;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    lane(0, 5'd1, 5'd2, 5'd3, 1'b1, 64'h1);
    bus.rob_gnt_cnt = 3'd1;
    #1;
    chk("rst_req", bus.rob_req_cnt, 3'd0);
    chk("rst_acc", bus.dec_accept_cnt, 3'd0);
    tick();
    tick();
    chk("rst_valid", bus.ren_valid, 4'd0);
    chk("rst_dest", bus.ren_dest_tag, 24'd0);
    chk("rst_payload", bus.ren_payload, 256'd0);
    rst = 1'b0;

    // in-group chain through x1
    idle();
    lane(0, 5'd0, 5'd0, 5'd1, 1'b1, 64'hA0);
    lane(1, 5'd1, 5'd0, 5'd1, 1'b1, 64'hA1);
    lane(2, 5'd1, 5'd0, 5'd0, 1'b0, 64'hA2);
    lane(3, 5'd3, 5'd0, 5'd0, 1'b0, 64'hA3);
    bus.rob_gnt_cnt = 3'd4;
    bus.rob_tag_base = 6'd10;
    #1;
    chk("chain_req", bus.rob_req_cnt, 3'd4);
    chk("chain_acc", bus.dec_accept_cnt, 3'd4);
    tick();
    chk("chain_valid", bus.ren_valid, 4'hF);
    chk("chain_dest", bus.ren_dest_tag,
        {6'd13, 6'd12, 6'd11, 6'd10});
    chk("chain_rs1_ren", bus.ren_rs1_renamed, 4'b0110);
    chk("chain_rs1_tag", bus.ren_rs1_tag,
        {6'd0, 6'd11, 6'd10, 6'd0});
    chk("chain_rs2_ren", bus.ren_rs2_renamed, 4'b0000);
    chk("chain_pl2", bus.ren_payload[191:128], 64'hA2);

    // RAT holds x1 -> 11
    idle();
    lane(0, 5'd1, 5'd2, 5'd0, 1'b0, 64'hB0);
    bus.rob_gnt_cnt = 3'd1;
    bus.rob_tag_base = 6'd14;
    tick();
    chk("rat_valid", bus.ren_valid, 4'b0001);
    chk("rat_rs1_ren", bus.ren_rs1_renamed, 4'b0001);
    chk("rat_rs1_tag", bus.ren_rs1_tag, {6'd0, 6'd0, 6'd0, 6'd11});
    chk("rat_rs2_ren", bus.ren_rs2_renamed, 4'b0000);
    chk("rat_dest", bus.ren_dest_tag, {6'd0, 6'd0, 6'd0, 6'd14});

    // partial grant, then re-presented remainder
    idle();
    lane(0, 5'd0, 5'd0, 5'd2, 1'b1, 64'hC0);
    lane(1, 5'd2, 5'd0, 5'd3, 1'b1, 64'hC1);
    lane(2, 5'd0, 5'd0, 5'd4, 1'b1, 64'hC2);
    lane(3, 5'd0, 5'd0, 5'd5, 1'b1, 64'hC3);
    bus.rob_gnt_cnt = 3'd2;
    bus.rob_tag_base = 6'd10;
    #1;
    chk("part_req", bus.rob_req_cnt, 3'd4);
    chk("part_acc", bus.dec_accept_cnt, 3'd2);
    tick();
    chk("part_valid", bus.ren_valid, 4'b0011);
    chk("part_dest", bus.ren_dest_tag, {6'd0, 6'd0, 6'd11, 6'd10});
    chk("part_rs1_tag", bus.ren_rs1_tag, {6'd0, 6'd0, 6'd10, 6'd0});
    chk("part_pl", bus.ren_payload, {64'd0, 64'd0, 64'hC1, 64'hC0});
    idle();
    lane(0, 5'd3, 5'd0, 5'd4, 1'b1, 64'hC2);
    lane(1, 5'd0, 5'd0, 5'd5, 1'b1, 64'hC3);
    bus.rob_gnt_cnt = 3'd2;
    bus.rob_tag_base = 6'd12;
    #1;
    chk("rep_req", bus.rob_req_cnt, 3'd2);
    tick();
    chk("rep_valid", bus.ren_valid, 4'b0011);
    chk("rep_dest", bus.ren_dest_tag, {6'd0, 6'd0, 6'd13, 6'd12});
    chk("rep_rs1_tag", bus.ren_rs1_tag, {6'd0, 6'd0, 6'd0, 6'd11});

    // tag wrap
    idle();
    for (int i = 0; i < 4; i++)
      lane(i, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0);
    bus.rob_gnt_cnt = 3'd4;
    bus.rob_tag_base = 6'd62;
    tick();
    chk("wrap_dest", bus.ren_dest_tag, {6'd1, 6'd0, 6'd63, 6'd62});

    // commit race: clear bypassed into same-cycle read
    idle();
    lane(0, 5'd0, 5'd0, 5'd5, 1'b1, 64'd0);
    bus.rob_gnt_cnt = 3'd1;
    bus.rob_tag_base = 6'd7;
    tick();
    idle();
    lane(0, 5'd5, 5'd0, 5'd0, 1'b0, 64'd0);
    bus.rob_gnt_cnt = 3'd1;
    bus.rob_tag_base = 6'd20;
    bus.commit_valid = 2'b01;
    bus.commit_rd = {5'd0, 5'd5};
    bus.commit_tag = {6'd0, 6'd7};
    tick();
    chk("race1_ren", bus.ren_rs1_renamed, 4'b0000);
    chk("race1_tag", bus.ren_rs1_tag, 24'd0);
    idle();
    lane(0, 5'd5, 5'd0, 5'd0, 1'b0, 64'd0);
    bus.rob_gnt_cnt = 3'd1;
    bus.rob_tag_base = 6'd21;
    tick();
    chk("race1_unmapped", bus.ren_rs1_renamed, 4'b0000);

    // commit race: same-cycle rename write wins
    idle();
    lane(0, 5'd0, 5'd0, 5'd5, 1'b1, 64'd0);
    bus.rob_gnt_cnt = 3'd1;
    bus.rob_tag_base = 6'd7;
    tick();
    idle();
    lane(0, 5'd0, 5'd0, 5'd5, 1'b1, 64'd0);
    bus.rob_gnt_cnt = 3'd1;
    bus.rob_tag_base = 6'd20;
    bus.commit_valid = 2'b10;
    bus.commit_rd = {5'd5, 5'd0};
    bus.commit_tag = {6'd7, 6'd0};
    tick();
    // stale commit alongside the read must not hide the mapping
    idle();
    lane(0, 5'd5, 5'd0, 5'd0, 1'b0, 64'd0);
    bus.rob_gnt_cnt = 3'd1;
    bus.rob_tag_base = 6'd22;
    bus.commit_valid = 2'b01;
    bus.commit_rd = {5'd0, 5'd5};
    bus.commit_tag = {6'd0, 6'd9};
    tick();
    chk("race2_ren", bus.ren_rs1_renamed, 4'b0001);
    chk("race2_tag", bus.ren_rs1_tag, {6'd0, 6'd0, 6'd0, 6'd20});
    idle();
    lane(0, 5'd5, 5'd0, 5'd0, 1'b0, 64'd0);
    bus.rob_gnt_cnt = 3'd1;
    tick();
    chk("stale_tag", bus.ren_rs1_tag, {6'd0, 6'd0, 6'd0, 6'd20});

    // x0 is never mapped
    idle();
    lane(0, 5'd0, 5'd0, 5'd0, 1'b1, 64'd0);
    lane(1, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0);
    bus.rob_gnt_cnt = 3'd2;
    bus.rob_tag_base = 6'd30;
    tick();
    chk("x0_grp_ren", bus.ren_rs1_renamed, 4'b0000);
    chk("x0_dest", bus.ren_dest_tag, {6'd0, 6'd0, 6'd31, 6'd30});
    idle();
    lane(0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0);
    bus.rob_gnt_cnt = 3'd1;
    tick();
    chk("x0_rat_ren", bus.ren_rs1_renamed, 4'b0000);

    // backpressure holds the group
    idle();
    lane(0, 5'd5, 5'd1, 5'd6, 1'b1, 64'hCAFE);
    bus.rob_gnt_cnt = 3'd1;
    bus.rob_tag_base = 6'd40;
    tick();
    chk("bp_load", bus.ren_valid, 4'b0001);
    idle();
    bus.disp_rdy = 1'b0;
    lane(0, 5'd6, 5'd0, 5'd7, 1'b1, 64'hD0);
    lane(1, 5'd0, 5'd0, 5'd8, 1'b1, 64'hD1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_req", bus.rob_req_cnt, 3'd0);
      chk("bp_acc", bus.dec_accept_cnt, 3'd0);
      tick();
      chk("bp_valid", bus.ren_valid, 4'b0001);
      chk("bp_dest", bus.ren_dest_tag, {6'd0, 6'd0, 6'd0, 6'd40});
      chk("bp_pl", bus.ren_payload[63:0], 64'hCAFE);
      chk("bp_rs1", bus.ren_rs1_tag, {6'd0, 6'd0, 6'd0, 6'd20});
      chk("bp_rs2", bus.ren_rs2_tag, {6'd0, 6'd0, 6'd0, 6'd11});
    end

    // flush empties outputs and RAT
    bus.flush = 1'b1;
    bus.disp_rdy = 1'b1;
    #1;
    chk("fl_req", bus.rob_req_cnt, 3'd0);
    chk("fl_acc", bus.dec_accept_cnt, 3'd0);
    tick();
    chk("fl_valid", bus.ren_valid, 4'b0000);
    chk("fl_pl", bus.ren_payload, 256'd0);
    idle();
    lane(0, 5'd5, 5'd6, 5'd0, 1'b0, 64'd0);
    lane(1, 5'd1, 5'd2, 5'd0, 1'b0, 64'd0);
    bus.rob_gnt_cnt = 3'd2;
    bus.rob_tag_base = 6'd50;
    tick();
    chk("fl_after_valid", bus.ren_valid, 4'b0011);
    chk("fl_rs1_ren", bus.ren_rs1_renamed, 4'b0000);
    chk("fl_rs2_ren", bus.ren_rs2_renamed, 4'b0000);

    // zero grant loads an empty group
    idle();
    lane(0, 5'd0, 5'd0, 5'd9, 1'b1, 64'hE0);
    lane(1, 5'd0, 5'd0, 5'd9, 1'b1, 64'hE1);
    bus.rob_gnt_cnt = 3'd0;
    #1;
    chk("g0_req", bus.rob_req_cnt, 3'd2);
    chk("g0_acc", bus.dec_accept_cnt, 3'd0);
    tick();
    chk("g0_valid", bus.ren_valid, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
